lpf_rgb_stream_packer: RTL
==========================

Name: lpf_rgb_stream_packer

Overview:
Downstream stage of bit_shift_low_pass_filter. It consumes the filter's three 24-bit channel outputs plus the valid and framing flags. Each channel is scaled to 8 bits with saturation, packed into one 24-bit RGB word, and buffered with its framing sideband in a small FIFO. The FIFO presents a ready/valid stream to the frame-buffer writer. The block also tracks frame and line structure and reports protocol violations and overflow, because the filter has no backpressure.

Parameters:
CH_W, 24, width of each input channel word
SHIFT, 0, right-shift applied to each channel before 8-bit saturation (0..CH_W-8)
FIFO_DEPTH, 16, entries in output FIFO (power of 2, at least 4)
CNT_W, 16, width of line and pixel counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_valid_in  in  1  channel words and flags are valid this cycle
soc_in  in  1  first valid pixel of a line
eoc_in  in  1  last valid pixel of a line
solf_in  in  1  first valid pixel of a frame
eolf_in  in  1  last valid pixel of a frame
pixel_in_red  in  CH_W  filtered red
pixel_in_green  in  CH_W  filtered green
pixel_in_blue  in  CH_W  filtered blue
out_valid  out  1  FIFO head is valid
out_ready  in  1  downstream accepts the head
out_data  out  24  {r[7:0], g[7:0], b[7:0]}
out_sol  out  1  head is the first pixel of a line
out_eol  out  1  head is the last pixel of a line
out_sof  out  1  head is the first pixel of a frame
out_eof  out  1  head is the last pixel of a frame
line_count  out  CNT_W  completed lines in the current frame
last_line_len  out  CNT_W  pixel count of the most recently completed line
frame_done  out  1  one-cycle pulse when an eolf pixel is accepted
overflow  out  1  sticky: a pixel was dropped because the FIFO was full
protocol_error  out  1  sticky: framing violation detected
clear_status  in  1  synchronous clear of overflow and protocol_error

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, counters 0. Reset asserted mid-frame discards FIFO contents immediately.
- Flags are ignored when pixel_valid_in=0.
- Stage 1 (registered): ch8 = (ch >> SHIFT) > 255 ? 255 : (ch >> SHIFT)[7:0]. Flags are registered alongside.
- Stage 2: push {data, sol, eol, sof, eof} (28 bits) into the FIFO.
- Latency: input at cycle N gives out_valid=1 at N+2 when the FIFO is empty.
- Push rule: push is accepted if FIFO not full, or if full and a pop occurs in the same cycle. Otherwise the pixel is dropped and overflow is set.
- Pop occurs when out_valid && out_ready. Head outputs hold stable while out_valid && !out_ready.
- FSM (evaluated on stage-1 valid pixels):
  - IDLE: solf&soc -> IN_LINE, line pixel count = 1.
  - IDLE: solf without soc -> protocol_error, treat as soc.
  - IDLE: any other valid pixel -> dropped (not pushed), protocol_error.
  - IN_LINE: count++.
  - IN_LINE, eoc -> last_line_len = count, line_count++, go to GAP.
  - IN_LINE, soc -> protocol_error, restart count at 1.
  - IN_LINE, solf -> protocol_error, restart the frame: line_count = 0.
  - GAP: soc -> IN_LINE, count = 1.
  - GAP: a pixel without soc -> protocol_error, treat as soc.
  - Any state, eolf -> frame_done pulse, go to IDLE. line_count holds until the next solf, then clears.
- A single pixel with all four flags set is a legal 1x1 frame: line_count = 1, last_line_len = 1, frame_done pulses.
- Counters saturate at all ones; they do not wrap.
- clear_status has priority over a new set in the same cycle only if no new event occurs that cycle. A new event wins, so the flag stays 1.

Decomposition:
- Package lpf_stream_pkg holds: typedef pix_flags_t (sol, eol, sof, eof); typedef fifo_word_t (data[23:0] + pix_flags_t); FSM enum frame_state_e {IDLE, IN_LINE, GAP}.
- Sub-module sync_fifo: parameterised width and depth, with full, empty and simultaneous push/pop on full.

Test Plan:
- Single 4x2 frame, SHIFT=0, channels 0x000010/0x000020/0x000030, out_ready=1 -> out_data=0x102030 at N+2; sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7; line_count=2, last_line_len=4, one frame_done pulse.
- Saturation: red=0x000100, SHIFT=0 -> r=0xFF. With SHIFT=1 -> r=0x80. green=0xFFFFFF, SHIFT=16 -> g=0xFF.
- Backpressure: out_ready=0, push 20 pixels, FIFO_DEPTH=16 -> 16 stored, overflow=1, then drain gives 16 words in order. clear_status sets overflow to 0.
- Full with simultaneous pop: FIFO full, out_ready=1 and valid input in the same cycle -> no drop, overflow stays 0.
- Protocol: valid pixel in IDLE without solf -> not output, protocol_error=1. soc in mid-line -> last_line_len not updated, count restarts.
- Reset mid-frame: reset_n low for 1 cycle with 5 entries queued -> out_valid=0 immediately, FSM IDLE, counters 0; the next solf frame is processed normally.

Source files
------------

// File: rtl/lpf_stream_pkg.sv
// Shared types for the RGB stream packer: pixel sideband, FIFO word and frame FSM states.
package lpf_stream_pkg;

    typedef struct packed {
        logic sol;
        logic eol;
        logic sof;
        logic eof;
    } pix_flags_t;

    typedef struct packed {
        logic [23:0] data;
        pix_flags_t  flags;
    } fifo_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_LINE = 2'd1,
        GAP     = 2'd2
    } frame_state_e;

    localparam int FIFO_W = $bits(fifo_word_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lpf_rgb_stream_packer.sv
// Scales filter channels to 8 bits, packs RGB with framing sideband into a FIFO,
// and tracks frame/line structure with sticky overflow and protocol-error status.
module lpf_rgb_stream_packer
    import lpf_stream_pkg::*;
#(
    parameter int CH_W       = 24,
    parameter int SHIFT      = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pixel_valid_in,
    input  logic             soc_in,
    input  logic             eoc_in,
    input  logic             solf_in,
    input  logic             eolf_in,
    input  logic [CH_W-1:0]  pixel_in_red,
    input  logic [CH_W-1:0]  pixel_in_green,
    input  logic [CH_W-1:0]  pixel_in_blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_data,
    output logic             out_sol,
    output logic             out_eol,
    output logic             out_sof,
    output logic             out_eof,
    output logic [CNT_W-1:0] line_count,
    output logic [CNT_W-1:0] last_line_len,
    output logic             frame_done,
    output logic             overflow,
    output logic             protocol_error,
    input  logic             clear_status
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0][CH_W-1:0] chan;
    logic [2:0][7:0]      ch8, s1_ch8;
    logic                 s1_vld, s1_soc, s1_eoc, s1_solf, s1_eolf;

    assign chan = {pixel_in_red, pixel_in_green, pixel_in_blue};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [CH_W-1:0] sh;
        assign sh     = chan[c] >> SHIFT;
        assign ch8[c] = (|sh[CH_W-1:8]) ? 8'hFF : sh[7:0];
    end

    // Flags are masked by valid so idle cycles never look like framing events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_ch8  <= '0;
            s1_soc  <= 1'b0;
            s1_eoc  <= 1'b0;
            s1_solf <= 1'b0;
            s1_eolf <= 1'b0;
        end else begin
            s1_vld  <= pixel_valid_in;
            s1_ch8  <= ch8;
            s1_soc  <= pixel_valid_in & soc_in;
            s1_eoc  <= pixel_valid_in & eoc_in;
            s1_solf <= pixel_valid_in & solf_in;
            s1_eolf <= pixel_valid_in & eolf_in;
        end
    end

    frame_state_e     state, state_nx;
    logic [CNT_W-1:0] pix_cnt, cnt_nx, lc_nx, lll_nx;
    logic             accept, restart, force_sol, err_evt, fd_nx, ovf_evt;
    logic             pop, fifo_full, fifo_empty;
    fifo_word_t       wword, rword;

    always_comb begin
        state_nx  = state;
        cnt_nx    = pix_cnt;
        lc_nx     = line_count;
        lll_nx    = last_line_len;
        accept    = 1'b0;
        restart   = 1'b0;
        force_sol = 1'b0;
        err_evt   = 1'b0;
        fd_nx     = 1'b0;
        if (s1_vld) begin
            accept = 1'b1;
            case (state)
                IDLE: begin
                    if (!s1_solf) begin
                        accept  = 1'b0;
                        err_evt = 1'b1;
                    end else begin
                        err_evt   = !s1_soc;
                        restart   = 1'b1;
                        force_sol = 1'b1;
                        lc_nx     = '0;
                    end
                end
                GAP: begin
                    restart   = 1'b1;
                    force_sol = 1'b1;
                    err_evt   = !s1_soc || s1_solf;
                    if (s1_solf) lc_nx = '0;
                end
                default: begin
                    if (s1_soc || s1_solf) begin
                        err_evt = 1'b1;
                        restart = 1'b1;
                    end
                    if (s1_solf) lc_nx = '0;
                end
            endcase
            if (accept) begin
                cnt_nx   = restart ? CNT_W'(1) : sat_inc(pix_cnt);
                state_nx = IN_LINE;
                if (s1_eoc) begin
                    lll_nx   = cnt_nx;
                    lc_nx    = sat_inc(lc_nx);
                    state_nx = GAP;
                end
                if (s1_eolf) begin
                    state_nx = IDLE;
                    fd_nx    = 1'b1;
                end
            end
        end
    end

    assign pop     = out_valid && out_ready;
    assign ovf_evt = accept && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pix_cnt        <= '0;
            line_count     <= '0;
            last_line_len  <= '0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state          <= state_nx;
            pix_cnt        <= cnt_nx;
            line_count     <= lc_nx;
            last_line_len  <= lll_nx;
            frame_done     <= fd_nx;
            overflow       <= ovf_evt ? 1'b1 : (clear_status ? 1'b0 : overflow);
            protocol_error <= err_evt ? 1'b1 : (clear_status ? 1'b0 : protocol_error);
        end
    end

    assign wword.data       = s1_ch8;
    assign wword.flags.sol  = s1_soc | force_sol;
    assign wword.flags.eol  = s1_eoc;
    assign wword.flags.sof  = s1_solf;
    assign wword.flags.eof  = s1_eolf;

    sync_fifo #(.W(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .pop     (pop),
        .wdata   (wword),
        .rdata   (rword),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields are forced to zero while empty so stale RAM never leaks out.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? rword.data      : '0;
    assign out_sol   = out_valid & rword.flags.sol;
    assign out_eol   = out_valid & rword.flags.eol;
    assign out_sof   = out_valid & rword.flags.sof;
    assign out_eof   = out_valid & rword.flags.eof;

endmodule
